// File: rtl/shift_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_ctrl_if
// Description : Launch/completion bundle between EX-stage control and the
//               iterative shift sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_seq_ctrl_if #(
  parameter int N   = 32,
  parameter int SHW = 5
);
  logic           start;
  logic [1:0]     op;
  logic [N-1:0]   a;
  logic [SHW-1:0] shamt;
  logic           busy;
  logic           done;
  logic [N-1:0]   result;

  modport master (
    output start, op, a, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, shamt,
    output busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_ctrl
// Description : SLL/SRL/SRA by iterating a one-bit shift stage once per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl #(
  parameter int N   = 32,
  parameter int SHW = 5
) (
  input  wire            clk,
  input  wire            rst,
  shift_seq_ctrl_if.slave bus
);

  localparam logic [1:0] c_op_sll = 2'b00;
  localparam logic [1:0] c_op_srl = 2'b01;
  localparam logic [1:0] c_op_rsv = 2'b10;
  localparam logic [1:0] c_op_sra = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_w;
  logic [SHW-1:0] r_cnt;
  logic [1:0]     r_op;
  logic           r_busy;
  logic           r_done;
  logic [N-1:0]   r_result;

  logic [N-1:0]   w_step;
  logic           w_pass;

  function automatic logic [N-1:0] f_step(input logic [N-1:0] w, input logic [1:0] op);
    case (op)
      c_op_sll: f_step = {w[N-2:0], 1'b0};
      c_op_srl: f_step = {1'b0, w[N-1:1]};
      c_op_sra: f_step = {w[N-1], w[N-1:1]};
      default:  f_step = w;
    endcase
  endfunction

  assign w_step = f_step(r_w, r_op);
  // Zero amount or the reserved opcode complete immediately with a unchanged.
  assign w_pass = (bus.shamt == '0) || (bus.op == c_op_rsv);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_w      <= '0;
      r_cnt    <= '0;
      r_op     <= c_op_sll;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_w   <= bus.a;
            r_cnt <= bus.shamt;
            r_op  <= bus.op;
            if (w_pass) begin
              r_state  <= ST_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= bus.a;
            end else begin
              r_state <= ST_SHIFT;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end

        ST_SHIFT: begin
          r_w   <= w_step;
          r_cnt <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) begin
            r_state  <= ST_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_step;
          end else begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule
`default_nettype wire
